// File: rtl/config_loader.sv
// Configuration loader: assembles IN_W-bit chunks into a shadow register and
// commits them to the connection-block configuration bus only after a complete frame.
module config_loader #(
  parameter  int CFG_W = 44,
  parameter  int IN_W  = 8,
  localparam int NW    = (CFG_W + IN_W - 1) / IN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [IN_W-1:0]  cfg_data,
  input  logic             cfg_last,
  output logic [CFG_W-1:0] c,
  output logic             cset,
  output logic             done,
  output logic             err,
  output logic             busy
);

  localparam int CNT_W   = $clog2(NW + 1);
  localparam int LAST_LO = (NW - 1) * IN_W;
  localparam int LAST_W  = CFG_W - LAST_LO;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NW);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN,
    COMMIT
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [CFG_W-1:0]   shadow_q, shadow_d;
  logic [CFG_W-1:0]   c_q, c_d;
  logic               cset_q, cset_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               accept;
  logic               wr_en;

  // ready depends on state alone, so it never combinationally follows cfg_valid
  assign accept  = cfg_valid & (state_q != COMMIT);
  assign cnt_inc = cnt_q + CNT_W'(1);
  assign wr_en   = accept & ((state_q == IDLE) | (state_q == LOAD));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its peers, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      c_q      <= '0;
      cset_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      c_q      <= c_d;
      cset_q   <= cset_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    c_d      = c_q;
    cset_d   = cset_q;
    done_d   = 1'b0;
    err_d    = err_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          err_d = 1'b0;
          if (!cfg_last) begin
            state_d = LOAD;
            cnt_d   = CNT_W'(1);
          end else if (NW == 1) begin
            state_d = COMMIT;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (accept) begin
          cnt_d = cnt_inc;
          if (cfg_last) begin
            if (cnt_inc == LAST_CNT) begin
              state_d = COMMIT;
            end else begin
              err_d   = 1'b1;
              state_d = IDLE;
              cnt_d   = '0;
            end
          end else if (cnt_inc == LAST_CNT) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (accept && cfg_last) begin
          err_d   = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      COMMIT: begin
        c_d     = shadow_q;
        cset_d  = 1'b1;
        done_d  = 1'b1;
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Final chunk is truncated: its upper padding bits have no home in the shadow
    if (wr_en) begin
      for (int k = 0; k < NW - 1; k++) begin
        if (cnt_q == CNT_W'(k)) shadow_d[k*IN_W +: IN_W] = cfg_data;
      end
      if (cnt_q == CNT_W'(NW - 1)) shadow_d[CFG_W-1:LAST_LO] = cfg_data[LAST_W-1:0];
    end
  end

  always_comb begin
    cfg_ready = !rst && (state_q != COMMIT);
    busy      = (state_q != IDLE);
  end

  assign c    = c_q;
  assign cset = cset_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_config_loader.sv
// Directed self-checking bench for config_loader: good frames, stalls, short and
// long frames, mid-frame reset and padding truncation.
module tb_config_loader;

  localparam int CFG_W = 44;
  localparam int IN_W  = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [IN_W-1:0]  cfg_data = '0;
  logic             cfg_last = 1'b0;
  logic [CFG_W-1:0] c;
  logic             cset;
  logic             done;
  logic             err;
  logic             busy;

  int n_checks = 0;
  int n_errors = 0;

  config_loader #(.CFG_W(CFG_W), .IN_W(IN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_data  (cfg_data),
    .cfg_last  (cfg_last),
    .c         (c),
    .cset      (cset),
    .done      (done),
    .err       (err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one chunk at a negedge and return at the negedge after its accept.
  task automatic send_chunk(input logic [7:0] d, input logic last);
    int waited = 0;
    cfg_valid = 1'b1;
    cfg_data  = d;
    cfg_last  = last;
    while (!cfg_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!cfg_ready) check("ready_timeout", 64'd0, 64'd1);
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d[8], input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      send_chunk(d[i], i == n - 1);
      if (gap > 0 && i < n - 1) begin
        cfg_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          check("stall_ready", 64'(cfg_ready), 64'd1);
        end
      end
    end
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
  endtask

  // Called right after a good frame's last accept: COMMIT cycle, then the done pulse.
  task automatic expect_commit(input string tag, input logic [CFG_W-1:0] exp_c);
    check({tag, "_commit_ready"}, 64'(cfg_ready), 64'd0);
    check({tag, "_commit_busy"}, 64'(busy), 64'd1);
    check({tag, "_commit_done0"}, 64'(done), 64'd0);
    @(negedge clk);
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_c"}, 64'(c), 64'(exp_c));
    check({tag, "_cset"}, 64'(cset), 64'd1);
    check({tag, "_ready_back"}, 64'(cfg_ready), 64'd1);
    @(negedge clk);
    check({tag, "_done_once"}, 64'(done), 64'd0);
  endtask

  logic [7:0] frame_a[8];
  logic [7:0] frame_b[8];
  logic [7:0] frame_bad[8];
  logic [7:0] frame_pad[8];
  logic [CFG_W-1:0] c_a;
  logic [CFG_W-1:0] c_b;

  initial begin
    frame_a   = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'h00, 8'h00};
    frame_b   = '{8'h10, 8'h32, 8'h54, 8'h76, 8'h98, 8'h0A, 8'h00, 8'h00};
    frame_bad = '{8'hFF, 8'hEE, 8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h99, 8'h88};
    frame_pad = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hF5, 8'h00, 8'h00};
    c_a = 44'hB89_6745_2301;
    c_b = 44'hA98_7654_3210;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", 64'(cfg_ready), 64'd0);
    check("rst_c", 64'(c), 64'd0);
    check("rst_cset", 64'(cset), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 64'(cfg_ready), 64'd1);

    // Back-to-back good frame
    send_frame(frame_a, 6, 0);
    expect_commit("b2b", c_a);

    // Same frame with 3-cycle stalls between chunks
    send_frame(frame_a, 6, 3);
    expect_commit("stall", c_a);
    check("stall_err", 64'(err), 64'd0);

    // Short frame: 4 chunks
    send_frame(frame_bad, 4, 0);
    check("short_err", 64'(err), 64'd1);
    check("short_busy", 64'(busy), 64'd0);
    check("short_c", 64'(c), 64'(c_a));
    check("short_cset", 64'(cset), 64'd1);
    @(negedge clk);
    check("short_no_done", 64'(done), 64'd0);
    check("short_err_sticky", 64'(err), 64'd1);

    // Long frame: 8 chunks, err clears on first accept, DRAIN swallows 7-8
    send_chunk(frame_bad[0], 1'b0);
    check("long_err_cleared", 64'(err), 64'd0);
    for (int i = 1; i < 6; i++) send_chunk(frame_bad[i], 1'b0);
    check("long_drain_busy", 64'(busy), 64'd1);
    check("long_drain_ready", 64'(cfg_ready), 64'd1);
    send_chunk(frame_bad[6], 1'b0);
    send_chunk(frame_bad[7], 1'b1);
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
    check("long_err", 64'(err), 64'd1);
    check("long_busy", 64'(busy), 64'd0);
    check("long_c", 64'(c), 64'(c_a));
    @(negedge clk);
    check("long_no_done", 64'(done), 64'd0);

    // Recovery frame clears err and commits
    send_chunk(frame_b[0], 1'b0);
    check("recover_err_cleared", 64'(err), 64'd0);
    for (int i = 1; i < 6; i++) send_chunk(frame_b[i], i == 5);
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
    expect_commit("recover", c_b);

    // Reset after chunk 3
    for (int i = 0; i < 3; i++) send_chunk(frame_a[i], 1'b0);
    cfg_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_c", 64'(c), 64'd0);
    check("midrst_cset", 64'(cset), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_no_done", 64'(done), 64'd0);
    send_frame(frame_a, 6, 0);
    expect_commit("after_rst", c_a);

    // Padding nibble in chunk 6 is dropped
    send_frame(frame_pad, 6, 1);
    expect_commit("pad", 44'h589_6745_2301);
    check("pad_top_nibble", 64'(c[43:40]), 64'h5);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
